sr_ff_driver: RTL and testbench

Command-side driver for the team's clocked SR flip-flop. It is the encoder in the other direction: it takes a target-state command (set, clear, toggle, hold) over a valid/ready handshake and turns it into a legal S/R pulse sequence. It then checks the flop's q/qbar feedback and reports done, or a timeout error.
It sits between a control FSM or bench sequencer and an sr_ff instance.

---
 rtl/sr_ff_driver.sv | 187 ++++++++++++++++++
 tb/tb_sr_ff_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: turns set/clear/toggle/hold commands into legal S/R pulses for an
// sr_ff, then watches the q/qbar feedback and reports done or a timeout error.
// Optional build macro SR_DRV_ILLEGAL_EN: op 11 drives s=r=1 for PULSE_W cycles
// and completes with an unconditional done instead of toggling.
module sr_ff_driver #(
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    output logic       s,
    output logic       r,
    input  logic       q,
    input  logic       qbar,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PCW-1:0] PCNT_LOAD = PCW'(PULSE_W - 1);
    localparam logic [TCW-1:0] TCNT_LOAD = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck
    } state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           target_q, target_d;
    logic           illegal_q, illegal_d;
    logic           ready_q, ready_d;
    logic           s_q, s_d;
    logic           r_q, r_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;

    logic accept;
    logic match;
    logic illegal_op;
    logic tgt;

`ifdef SR_DRV_ILLEGAL_EN
    assign illegal_op = (req_op == 2'b11);
`else
    assign illegal_op = 1'b0;
`endif

    assign accept = req_valid & ready_q;
    assign match  = (q == target_q) && (qbar == ~target_q);

    // Target decode from the command and the q value seen at the accept edge.
    always_comb begin
        tgt = q;
        unique case (req_op)
            2'b01:   tgt = 1'b0;
            2'b10:   tgt = 1'b1;
            2'b11:   tgt = ~q;
            default: tgt = q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        tcnt_d    = tcnt_q;
        target_d  = target_q;
        illegal_d = illegal_q;
        ready_d   = ready_q;
        s_d       = s_q;
        r_d       = r_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                s_d     = 1'b0;
                r_d     = 1'b0;
                if (accept) begin
                    ready_d   = 1'b0;
                    target_d  = tgt;
                    illegal_d = illegal_op;
                    if (req_op == 2'b00) begin
                        // Hold: nothing to drive, just confirm the current state.
                        state_d = StCheck;
                        tcnt_d  = TCNT_LOAD;
                    end else begin
                        state_d = StDrive;
                        pcnt_d  = PCNT_LOAD;
                        if (illegal_op) begin
                            s_d = 1'b1;
                            r_d = 1'b1;
                        end else begin
                            s_d = tgt;
                            r_d = ~tgt;
                        end
                    end
                end
            end

            StDrive: begin
                ready_d = 1'b0;
                if (pcnt_q == '0) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    tcnt_d  = TCNT_LOAD;
                    state_d = StCheck;
                end else begin
                    pcnt_d = pcnt_q - PCW'(1);
                end
            end

            StCheck: begin
                ready_d = 1'b0;
                s_d     = 1'b0;
                r_d     = 1'b0;
                if (illegal_q || match) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if (tcnt_q == '0) begin
                    err_d     = 1'b1;
                    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    ready_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tcnt_d = tcnt_q - TCW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                s_d     = 1'b0;
                r_d     = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pcnt_q    <= '0;
            tcnt_q    <= '0;
            target_q  <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            tcnt_q    <= tcnt_d;
            target_q  <= target_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign req_ready = ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver: instance a (PULSE_W=1) covers set/clear,
// toggle/hold and timeout; instance b (PULSE_W=4) covers busy and reset abort.
module tb_sr_ff_driver;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_op;
    logic       tie;

    logic       rdy_a, s_a, r_a, q_a, qb_a, done_a, err_a;
    logic [7:0] cnt_a;
    logic       rdy_b, s_b, r_b, q_b, qb_b, done_b, err_b;
    logic [7:0] cnt_b;
    logic       fq_a, fq_b;

    int total = 0;
    int bad = 0;
    int sr_hits = 0;

    sr_ff_driver #(.PULSE_W(1), .TIMEOUT(4)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
        .req_op(req_op), .s(s_a), .r(r_a), .q(q_a), .qbar(qb_a),
        .done(done_a), .err(err_a), .err_cnt(cnt_a)
    );

    sr_ff_driver #(.PULSE_W(4), .TIMEOUT(4)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b),
        .req_op(req_op), .s(s_b), .r(r_b), .q(q_b), .qbar(qb_b),
        .done(done_b), .err(err_b), .err_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocked SR flop models: q updates on the edge that samples s/r.
    always @(posedge clk or negedge reset) begin
        if (!reset) fq_a <= 1'b0;
        else if (s_a & ~r_a) fq_a <= 1'b1;
        else if (r_a & ~s_a) fq_a <= 1'b0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) fq_b <= 1'b0;
        else if (s_b & ~r_b) fq_b <= 1'b1;
        else if (r_b & ~s_b) fq_b <= 1'b0;
    end

    assign q_a  = tie ? 1'b0 : fq_a;
    assign qb_a = ~q_a;
    assign q_b  = fq_b;
    assign qb_b = ~q_b;

    // Record any cycle where either driver asserts s and r together.
    always @(negedge clk) begin
        if ((s_a & r_a) | (s_b & r_b)) sr_hits++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One command on instance a that the flop model completes normally.
    task automatic cmd_a(input logic [1:0] op, input logic es, input logic er,
                         input logic eq, input string tag);
        req_valid = 1'b1;
        req_op    = op;
        tick();
        req_valid = 1'b0;
        chk({tag, "_s"}, s_a, es);
        chk({tag, "_r"}, r_a, er);
        chk({tag, "_busy"}, rdy_a, 1'b0);
        if (op != 2'b00) begin
            tick();
            chk({tag, "_s_off"}, s_a, 1'b0);
            chk({tag, "_r_off"}, r_a, 1'b0);
            chk({tag, "_q"}, q_a, eq);
        end
        tick();
        chk({tag, "_done"}, done_a, 1'b1);
        chk({tag, "_err"}, err_a, 1'b0);
        chk({tag, "_ready"}, rdy_a, 1'b1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        tie       = 1'b0;

        // Reset held two cycles, then released.
        tick();
        tick();
        chk("rst_ready", rdy_a, 1'b0);
        chk("rst_s", s_a, 1'b0);
        chk("rst_r", r_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_cnt", cnt_a, 8'd0);
        reset = 1'b1;
        tick();
        chk("rel_ready", rdy_a, 1'b1);
        chk("rel_done", done_a, 1'b0);
        chk("rel_err", err_a, 1'b0);

        // Set then clear.
        cmd_a(2'b10, 1'b1, 1'b0, 1'b1, "set");
        cmd_a(2'b01, 1'b0, 1'b1, 1'b0, "clr");
        chk("setclr_cnt", cnt_a, 8'd0);

`ifdef SR_DRV_ILLEGAL_EN
        // Forced illegal drive, then unconditional done.
        req_valid = 1'b1;
        req_op    = 2'b11;
        tick();
        req_valid = 1'b0;
        chk("ill_s", s_a, 1'b1);
        chk("ill_r", r_a, 1'b1);
        tick();
        chk("ill_s_off", s_a, 1'b0);
        chk("ill_r_off", r_a, 1'b0);
        tick();
        chk("ill_done", done_a, 1'b1);
        // Bring the flop back to q=0 for the following steps.
        cmd_a(2'b01, 1'b0, 1'b1, 1'b0, "ill_clr");
`else
        // Toggle from q=0, toggle back, then hold.
        cmd_a(2'b11, 1'b1, 1'b0, 1'b1, "tog1");
        cmd_a(2'b11, 1'b0, 1'b1, 1'b0, "tog0");
`endif
        cmd_a(2'b00, 1'b0, 1'b0, 1'b0, "hold");

        // Timeout with q stuck at 0: err four cycles after s falls.
        tie       = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b10;
        tick();
        req_valid = 1'b0;
        chk("to_s", s_a, 1'b1);
        tick();
        chk("to_s_off", s_a, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_wait_err", err_a, 1'b0);
            chk("to_wait_done", done_a, 1'b0);
        end
        tick();
        chk("to_err", err_a, 1'b1);
        chk("to_done", done_a, 1'b0);
        chk("to_cnt", cnt_a, 8'd1);
        chk("to_ready", rdy_a, 1'b1);
        tick();
        chk("to_err_pulse", err_a, 1'b0);

        // Match appearing on the last timeout cycle is done, not err.
        req_valid = 1'b1;
        req_op    = 2'b10;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        tie = 1'b0;
        tick();
        chk("last_done", done_a, 1'b1);
        chk("last_err", err_a, 1'b0);
        chk("last_cnt", cnt_a, 8'd1);

        // Repeated timeouts saturate the error count.
        tie = 1'b1;
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b10;
            tick();
            req_valid = 1'b0;
            repeat (5) tick();
            chk("sat_err", err_a, 1'b1);
            chk("sat_cnt", cnt_a, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end
        tie = 1'b0;

        // Busy: a second command during DRIVE is ignored (PULSE_W=4).
        reset = 1'b0;
        tick();
        chk("rst2_cnt", cnt_a, 8'd0);
        reset = 1'b1;
        tick();
        chk("b_ready", rdy_b, 1'b1);
        req_valid = 1'b1;
        req_op    = 2'b10;
        tick();
        chk("b_s0", s_b, 1'b1);
        chk("b_r0", r_b, 1'b0);
        chk("b_busy0", rdy_b, 1'b0);
        req_op = 2'b01;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("b_s", s_b, 1'b1);
            chk("b_r", r_b, 1'b0);
            chk("b_busy", rdy_b, 1'b0);
        end
        tick();
        chk("b_s_off", s_b, 1'b0);
        chk("b_early_done", done_b, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("b_done", done_b, 1'b1);
        chk("b_q", q_b, 1'b1);
        tick();
        chk("b_idle_ready", rdy_b, 1'b1);
        chk("b_idle_s", s_b, 1'b0);
        chk("b_idle_r", r_b, 1'b0);

        // Reset during DRIVE drops r at once and yields no done/err.
        req_valid = 1'b1;
        req_op    = 2'b01;
        tick();
        req_valid = 1'b0;
        chk("ab_r", r_b, 1'b1);
        tick();
        chk("ab_r_held", r_b, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("ab_r_async", r_b, 1'b0);
        chk("ab_s_async", s_b, 1'b0);
        chk("ab_ready_async", rdy_b, 1'b0);
        repeat (2) begin
            tick();
            chk("ab_rst_done", done_b, 1'b0);
            chk("ab_rst_err", err_b, 1'b0);
        end
        reset = 1'b1;
        repeat (6) begin
            tick();
            chk("ab_post_done", done_b, 1'b0);
            chk("ab_post_err", err_b, 1'b0);
            chk("ab_post_r", r_b, 1'b0);
        end
        chk("ab_cnt", cnt_b, 8'd0);

`ifndef SR_DRV_ILLEGAL_EN
        chk("s_and_r_never", sr_hits, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
